// File: rtl/vga_window_gen.sv
// VGA timing generator with a movable rectangular window; moves are applied in vertical blanking.
// Define WIN_WRAP_EN to make window moves wrap around the visible range instead of clamping.
module vga_window_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int WIN_W     = 8,
  parameter int WIN_H     = 16,
  parameter int X_INIT    = 316,
  parameter int Y_INIT    = 232,
  parameter int STEP      = 1,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL),
  localparam int CW       = (WIN_W > 1) ? $clog2(WIN_W) : 1,
  localparam int RW       = (WIN_H > 1) ? $clog2(WIN_H) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mv_valid,
  input  logic [1:0]    mv_dir,
  output logic          pix_en,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          hsync,
  output logic          vsync,
  output logic          visible,
  output logic          display_area,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          frame_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] HS_FIRST = XW'(H_VISIBLE + H_FRONT);
  localparam logic [XW-1:0] HS_LAST  = XW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [YW-1:0] VS_FIRST = YW'(V_VISIBLE + V_FRONT);
  localparam logic [YW-1:0] VS_LAST  = YW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [XW-1:0] X_VIS    = XW'(H_VISIBLE);
  localparam logic [YW-1:0] Y_VIS    = YW'(V_VISIBLE);
  localparam logic [XW-1:0] X_MAX    = XW'(H_VISIBLE - WIN_W);
  localparam logic [YW-1:0] Y_MAX    = YW'(V_VISIBLE - WIN_H);
  localparam logic [XW:0]   X_RANGE  = (XW+1)'(H_VISIBLE - WIN_W + 1);
  localparam logic [YW:0]   Y_RANGE  = (YW+1)'(V_VISIBLE - WIN_H + 1);
  localparam logic [XW:0]   STEP_X   = (XW+1)'(STEP);
  localparam logic [YW:0]   STEP_Y   = (YW+1)'(STEP);
  localparam logic [XW:0]   WIN_W_X  = (XW+1)'(WIN_W);
  localparam logic [YW:0]   WIN_H_Y  = (YW+1)'(WIN_H);
  localparam logic [XW-1:0] X_START  = XW'(X_INIT);
  localparam logic [YW-1:0] Y_START  = YW'(Y_INIT);
  localparam logic          H_ACT    = (HSYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic          V_ACT    = (VSYNC_POL != 0) ? 1'b1 : 1'b0;

  logic [DW-1:0] div_r;
  logic          pix_en_r;
  logic [XW-1:0] pix_x_r;
  logic [YW-1:0] pix_y_r;
  logic [XW-1:0] win_x_r;
  logic [YW-1:0] win_y_r;
  logic          pend_v_r;
  logic [1:0]    pend_dir_r;

  logic          apply_s;
  logic [XW:0]   sum_x_s;
  logic [YW:0]   sum_y_s;
  logic [XW-1:0] x_low_s, x_high_s, next_x_s;
  logic [YW-1:0] y_low_s, y_high_s, next_y_s;
  logic          in_x_s, in_y_s, disp_s;

  // Clock divider: pix_en is high for one clk after every CLK_DIV-th edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r    <= '0;
      pix_en_r <= 1'b0;
    end else begin
      pix_en_r <= (div_r == DIV_LAST);
      if (div_r == DIV_LAST) begin
        div_r <= '0;
      end else begin
        div_r <= div_r + 1'b1;
      end
    end
  end

  // Raster counters advance at the end of each pixel-enable cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_x_r <= '0;
      pix_y_r <= '0;
    end else if (pix_en_r) begin
      if (pix_x_r == X_LAST) begin
        pix_x_r <= '0;
        if (pix_y_r == Y_LAST) begin
          pix_y_r <= '0;
        end else begin
          pix_y_r <= pix_y_r + 1'b1;
        end
      end else begin
        pix_x_r <= pix_x_r + 1'b1;
      end
    end else begin
      pix_x_r <= pix_x_r;
      pix_y_r <= pix_y_r;
    end
  end

  assign apply_s = pix_en_r && (pix_x_r == '0) && (pix_y_r == Y_VIS);

  // Pending move slot: a new request always wins, even on the apply clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_v_r   <= 1'b0;
      pend_dir_r <= 2'b00;
    end else if (mv_valid) begin
      pend_v_r   <= 1'b1;
      pend_dir_r <= mv_dir;
    end else if (apply_s) begin
      pend_v_r   <= 1'b0;
    end else begin
      pend_v_r   <= pend_v_r;
    end
  end

  // Out-of-range targets for the moved window edge.
  always_comb begin
    sum_x_s = {1'b0, win_x_r} + STEP_X;
    sum_y_s = {1'b0, win_y_r} + STEP_Y;
`ifdef WIN_WRAP_EN
    x_low_s  = XW'({1'b0, win_x_r} + X_RANGE - STEP_X);
    x_high_s = XW'(sum_x_s - X_RANGE);
    y_low_s  = YW'({1'b0, win_y_r} + Y_RANGE - STEP_Y);
    y_high_s = YW'(sum_y_s - Y_RANGE);
`else
    x_low_s  = '0;
    x_high_s = X_MAX;
    y_low_s  = '0;
    y_high_s = Y_MAX;
`endif
  end

  // Candidate window position for the pending direction.
  always_comb begin
    next_x_s = win_x_r;
    next_y_s = win_y_r;
    case (pend_dir_r)
      2'b00: begin
        if ({1'b0, win_y_r} < STEP_Y) next_y_s = y_low_s;
        else                          next_y_s = YW'({1'b0, win_y_r} - STEP_Y);
      end
      2'b01: begin
        if (sum_y_s > {1'b0, Y_MAX}) next_y_s = y_high_s;
        else                         next_y_s = YW'(sum_y_s);
      end
      2'b10: begin
        if ({1'b0, win_x_r} < STEP_X) next_x_s = x_low_s;
        else                          next_x_s = XW'({1'b0, win_x_r} - STEP_X);
      end
      2'b11: begin
        if (sum_x_s > {1'b0, X_MAX}) next_x_s = x_high_s;
        else                         next_x_s = XW'(sum_x_s);
      end
      default: begin
        next_x_s = win_x_r;
        next_y_s = win_y_r;
      end
    endcase
  end

  // Window position register, updated only in vertical blanking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_x_r <= X_START;
      win_y_r <= Y_START;
    end else if (apply_s && pend_v_r) begin
      win_x_r <= next_x_s;
      win_y_r <= next_y_s;
    end else begin
      win_x_r <= win_x_r;
      win_y_r <= win_y_r;
    end
  end

  // Zero-latency decodes of the registered counters.
  always_comb begin
    in_x_s = (pix_x_r >= win_x_r) && ({1'b0, pix_x_r} < ({1'b0, win_x_r} + WIN_W_X));
    in_y_s = (pix_y_r >= win_y_r) && ({1'b0, pix_y_r} < ({1'b0, win_y_r} + WIN_H_Y));
    disp_s = in_x_s && in_y_s;
  end

  assign pix_en       = pix_en_r;
  assign pix_x        = pix_x_r;
  assign pix_y        = pix_y_r;
  assign hsync        = ((pix_x_r >= HS_FIRST) && (pix_x_r <= HS_LAST)) ? H_ACT : ~H_ACT;
  assign vsync        = ((pix_y_r >= VS_FIRST) && (pix_y_r <= VS_LAST)) ? V_ACT : ~V_ACT;
  assign visible      = (pix_x_r < X_VIS) && (pix_y_r < Y_VIS);
  assign display_area = disp_s;
  assign win_col      = disp_s ? CW'(pix_x_r - win_x_r) : '0;
  assign win_row      = disp_s ? RW'(pix_y_r - win_y_r) : '0;
  assign frame_start  = pix_en_r && (pix_x_r == '0) && (pix_y_r == '0);

endmodule

// File: tb/tb_vga_window_gen.sv
// Bench for vga_window_gen on a shrunken raster (24x17 totals, 16x12 visible, 4x3 window, STEP 2).
module tb_vga_window_gen;

  localparam int D  = 2;
  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 12, VF = 1, VS = 2, VB = 2;
  localparam int HP = 0, VP = 1;
  localparam int WW = 4, WH = 3, XI = 5, YI = 4, ST = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int XMAX = HV - WW;
  localparam int YMAX = VV - WH;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mv_valid = 1'b0;
  logic [1:0] mv_dir = 2'b00;

  logic       pix_en, hsync, vsync, visible, display_area, frame_start;
  logic [4:0] pix_x, pix_y;
  logic [1:0] win_col, win_row;

  logic       p1_en, p1_hs, p1_vs, p1_vis, p1_disp, p1_fs;
  logic [4:0] p1_x, p1_y;
  logic [1:0] p1_col, p1_row;

  int checks = 0;
  int errors = 0;

  vga_window_gen #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .WIN_W(WW), .WIN_H(WH),
    .X_INIT(XI), .Y_INIT(YI), .STEP(ST)
  ) u_dut (
    .clk(clk), .reset(reset), .mv_valid(mv_valid), .mv_dir(mv_dir),
    .pix_en(pix_en), .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .visible(visible), .display_area(display_area), .win_col(win_col),
    .win_row(win_row), .frame_start(frame_start)
  );

  vga_window_gen #(
    .CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .WIN_W(WW), .WIN_H(WH),
    .X_INIT(XI), .Y_INIT(YI), .STEP(ST)
  ) u_dut_div1 (
    .clk(clk), .reset(reset), .mv_valid(mv_valid), .mv_dir(mv_dir),
    .pix_en(p1_en), .pix_x(p1_x), .pix_y(p1_y), .hsync(p1_hs), .vsync(p1_vs),
    .visible(p1_vis), .display_area(p1_disp), .win_col(p1_col),
    .win_row(p1_row), .frame_start(p1_fs)
  );

  always #5 clk = ~clk;

  // Reference model: raster position is a pure function of clks since reset release.
  int n_edges = 0;
  int m_wx = XI, m_wy = YI, m_pend = 0, m_dir = 0;
  int k, px, py, e_col, e_row;
  logic e_en, e_hs, e_vs, e_vis, e_disp, e_fs, e_apply;
  logic [19:0] exp_v, act_v;

  function automatic int bound_pos(input int v, input int maxv);
`ifdef WIN_WRAP_EN
    return ((v % (maxv + 1)) + (maxv + 1)) % (maxv + 1);
`else
    if (v < 0) return 0;
    else if (v > maxv) return maxv;
    else return v;
`endif
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      n_edges = 0;
      m_wx = XI;
      m_wy = YI;
      m_pend = 0;
    end
    k      = (n_edges == 0) ? 0 : (n_edges - 1) / D;
    e_en   = (n_edges > 0) && (n_edges % D == 0);
    px     = k % HT;
    py     = (k / HT) % VT;
    e_hs   = ((px >= HV + HF) && (px < HV + HF + HS)) ? (HP != 0) : (HP == 0);
    e_vs   = ((py >= VV + VF) && (py < VV + VF + VS)) ? (VP != 0) : (VP == 0);
    e_vis  = (px < HV) && (py < VV);
    e_disp = (px >= m_wx) && (px < m_wx + WW) && (py >= m_wy) && (py < m_wy + WH);
    e_col  = e_disp ? px - m_wx : 0;
    e_row  = e_disp ? py - m_wy : 0;
    e_fs   = e_en && (px == 0) && (py == 0);
    exp_v  = {e_en, 5'(px), 5'(py), e_hs, e_vs, e_vis, e_disp, 2'(e_col), 2'(e_row), e_fs};
    act_v  = {pix_en, pix_x, pix_y, hsync, vsync, visible, display_area, win_col, win_row, frame_start};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_cmp t=%0t: got %h (x=%0d y=%0d) want %h (x=%0d y=%0d)",
               $time, act_v, pix_x, pix_y, exp_v, px, py);
    end
    checks++;
    if (p1_en !== (reset && (n_edges >= 1))) begin
      errors++;
      $display("FAIL div1_pix_en t=%0t: got %b want %b", $time, p1_en, reset && (n_edges >= 1));
    end
    if (reset) begin
      e_apply = e_en && (px == 0) && (py == VV);
      if (e_apply) begin
        if (m_pend != 0) begin
          case (m_dir)
            0: m_wy = bound_pos(m_wy - ST, YMAX);
            1: m_wy = bound_pos(m_wy + ST, YMAX);
            2: m_wx = bound_pos(m_wx - ST, XMAX);
            default: m_wx = bound_pos(m_wx + ST, XMAX);
          endcase
        end
        m_pend = 0;
      end
      if (mv_valid) begin
        m_pend = 1;
        m_dir = int'(mv_dir);
      end
      n_edges++;
    end
  end

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_pix(input int x, input int y);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (pix_en === 1'b1 && pix_x == 5'(x) && pix_y == 5'(y)) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_pix(%0d,%0d): not reached within 2000 clks", x, y);
    end
  endtask

  task automatic request(input logic [1:0] dir);
    mv_dir = dir;
    mv_valid = 1'b1;
    @(posedge clk);
    #1;
    mv_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    bit seen;
    #1;
    check_val("rst_visible", int'(visible), 1);
    check_val("rst_hsync", int'(hsync), 1);
    check_val("rst_vsync", int'(vsync), 0);
    check_val("rst_pix_en", int'(pix_en), 0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("pix_en_edge1", int'(pix_en), 0);
    @(posedge clk); #1;
    check_val("pix_en_edge2", int'(pix_en), 1);
    check_val("first_frame_start", int'(frame_start), 1);
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (frame_start === 1'b1) seen = 1'b1;
    end
    check_val("frame_period", cnt, 2 * HT * VT);

    // Reset window at (5,4); sync/visible boundaries.
    wait_pix(6, 5);   check_val("win_in", int'(display_area), 1);
                      check_val("win_col", int'(win_col), 1);
                      check_val("win_row", int'(win_row), 1);
    wait_pix(9, 5);   check_val("win_right_edge", int'(display_area), 0);
    wait_pix(8, 6);   check_val("win_corner_col", int'(win_col), 3);
                      check_val("win_corner_row", int'(win_row), 2);
    wait_pix(8, 7);   check_val("win_below", int'(display_area), 0);
    wait_pix(18, 8);  check_val("hsync_first", int'(hsync), 0);
    wait_pix(21, 8);  check_val("hsync_after", int'(hsync), 1);
    wait_pix(15, 11); check_val("visible_last", int'(visible), 1);
    wait_pix(16, 11); check_val("visible_front", int'(visible), 0);
    wait_pix(0, 13);  check_val("vsync_first", int'(vsync), 1);
    wait_pix(0, 15);  check_val("vsync_after", int'(vsync), 0);

    // Right move mid-frame takes effect only from the next frame.
    wait_pix(0, 3);
    request(2'b11);
    wait_pix(5, 4);   check_val("move_deferred", int'(display_area), 1);
    wait_pix(5, 4);   check_val("move_old_left", int'(display_area), 0);
    wait_pix(7, 4);   check_val("move_new_left", int'(display_area), 1);

    // Up, left, down in one frame: only down applies.
    wait_pix(0, 6);
    request(2'b00);
    repeat (3) @(posedge clk);
    #1;
    request(2'b10);
    request(2'b01);
    wait_pix(7, 5);   check_val("last_wins_above", int'(display_area), 0);
    wait_pix(7, 6);   check_val("last_wins_top", int'(display_area), 1);
                      check_val("last_wins_row", int'(win_row), 0);

    // Right moves 7->9->11->12 (clamp lands on bound) or wrap to 0.
    for (int i = 0; i < 3; i++) begin
      wait_pix(0, 1);
      request(2'b11);
    end
    wait_pix(0, 13);
`ifdef WIN_WRAP_EN
    wait_pix(0, 7);   check_val("wrap_x_in", int'(display_area), 1);
    wait_pix(4, 7);   check_val("wrap_x_out", int'(display_area), 0);
`else
    wait_pix(11, 7);  check_val("clamp_x_out", int'(display_area), 0);
    wait_pix(12, 7);  check_val("clamp_x_in", int'(display_area), 1);
    wait_pix(15, 7);  check_val("clamp_x_col", int'(win_col), 3);
`endif

    // Up moves past the top edge.
    for (int i = 0; i < 4; i++) begin
      wait_pix(0, 1);
      request(2'b00);
    end
    wait_pix(0, 13);
`ifndef WIN_WRAP_EN
    wait_pix(12, 0);  check_val("clamp_y_top", int'(display_area), 1);
    wait_pix(12, 3);  check_val("clamp_y_below", int'(display_area), 0);
`endif

    // Request on the apply clk stays pending for the following frame.
    wait_pix(0, 12);
    request(2'b10);
    wait_pix(10, 0);
`ifndef WIN_WRAP_EN
    check_val("apply_clk_held", int'(display_area), 0);
`endif
    wait_pix(0, 13);
    wait_pix(10, 0);
`ifndef WIN_WRAP_EN
    check_val("apply_clk_applied", int'(display_area), 1);
    check_val("apply_clk_col", int'(win_col), 0);
`endif

    // Pending request discarded by a mid-frame reset.
    wait_pix(0, 12);
    request(2'b11);
    wait_pix(0, 3);
    reset = 1'b0;
    #1;
    check_val("midrst_pix_en", int'(pix_en), 0);
    check_val("midrst_pix_y", int'(pix_y), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_pix(4, 4);   check_val("rst_win_left_out", int'(display_area), 0);
    wait_pix(5, 4);   check_val("rst_win_left_in", int'(display_area), 1);
                      check_val("rst_win_row", int'(win_row), 0);
    wait_pix(0, 13);
    wait_pix(4, 4);   check_val("no_stale_move_out", int'(display_area), 0);
    wait_pix(5, 4);   check_val("no_stale_move_in", int'(display_area), 1);
    wait_pix(7, 6);   check_val("no_stale_move_col", int'(win_col), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_window_gen.md
VGA_WINDOW_GEN -- requirements
Module: vga_window_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- CLK_DIV, 2, clk cycles per pixel (>=1)
- H_VISIBLE, 640, visible pixels
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- HSYNC_POL, 0, hsync active level
- VSYNC_POL, 0, vsync active level
- WIN_W, 8, window width (pixels)
- WIN_H, 16, window height (lines)
- X_INIT, 316, reset window left edge
- Y_INIT, 232, reset window top edge
- STEP, 1, pixels moved per request

REQ-002 Ports SHALL be (name, direction, width, meaning), one per line:
- clk, in, 1, single system clock; all logic on its rising edge
- reset, in, 1, asynchronous, active-low reset
- mv_valid, in, 1, one-clk move request strobe
- mv_dir, in, 2, direction: 00 up, 01 down, 10 left, 11 right
- pix_en, out, 1, pixel-rate enable
- pix_x, out, clog2(H_TOTAL), horizontal counter
- pix_y, out, clog2(V_TOTAL), vertical counter
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- visible, out, 1, inside active video
- display_area, out, 1, inside window
- win_col, out, clog2(WIN_W), column offset inside window
- win_row, out, clog2(WIN_H), row offset inside window
- frame_start, out, 1, frame start pulse

Function
REQ-003 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL SHALL equal the vertical sum (defaults 800/525).
REQ-004 pix_en SHALL pulse high for one clk every CLK_DIV clks; the first pulse SHALL occur on the CLK_DIV-th clk after reset release; with CLK_DIV=1, pix_en SHALL be constantly 1.
REQ-005 pix_x SHALL increment on pix_en and wrap H_TOTAL-1 -> 0; pix_y SHALL increment on that wrap and wrap V_TOTAL-1 -> 0.
REQ-006 Order per line and frame SHALL be visible, front porch, sync, back porch; hsync SHALL equal HSYNC_POL for pix_x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], else its inverse; vsync SHALL be the vertical analogue.
REQ-007 visible SHALL be 1 iff pix_x<H_VISIBLE and pix_y<V_VISIBLE.
REQ-008 hsync, vsync, visible, display_area, win_col and win_row SHALL be combinational decodes of the registered counters, aligned with pix_x and pix_y (zero latency).
REQ-009 display_area SHALL be 1 iff win_x<=pix_x<win_x+WIN_W and win_y<=pix_y<win_y+WIN_H; win_col and win_row SHALL equal pix_x-win_x and pix_y-win_y when display_area=1, else 0.
REQ-010 frame_start SHALL be 1 for exactly the one clk where pix_en=1, pix_x=0 and pix_y=0.
REQ-011 On mv_valid, mv_dir SHALL be latched into a pending slot; a later request in the same frame SHALL overwrite it (last wins).
REQ-012 The pending move SHALL be applied, and the slot cleared, on the pix_en where pix_x=0 and pix_y=V_VISIBLE (blanking only, tear-free).
REQ-013 A request arriving on the apply clk SHALL remain pending for the next frame, not be dropped.
REQ-014 Without the REQ-017 macro, win_x SHALL clamp to [0, H_VISIBLE-WIN_W] and win_y to [0, V_VISIBLE-WIN_H]; a move crossing a bound SHALL land exactly on that bound.

Reset
REQ-015 While reset=0: divider, pix_x and pix_y SHALL be 0; win_x=X_INIT and win_y=Y_INIT; pending cleared; pix_en=0; frame_start=0; hsync=!HSYNC_POL; vsync=!VSYNC_POL; visible=1; display_area per REQ-009.
REQ-016 Reset asserted mid-frame SHALL take immediate effect; a pending move SHALL be discarded.

Configuration
REQ-017 With WIN_WRAP_EN defined, a move past a bound SHALL wrap modulo the range (x modulo H_VISIBLE-WIN_W+1, y modulo V_VISIBLE-WIN_H+1); undefined, clamping per REQ-014 SHALL apply.

Verification
REQ-018 Defaults, reset released -> pix_en every 2nd clk; hsync low for pix_x 656..751; vsync low for pix_y 490..491; frame_start once every 840000 clks.
REQ-019 Reset -> display_area=1 for pix_x 316..323 and pix_y 232..247; win_row=5 at pix_y=237.
REQ-020 mv_valid with dir=11 at pix_y=100 -> window unchanged through line 479; from the next frame, display_area spans pix_x 317..324.
REQ-021 Three requests in one frame (up, left, down) -> only down is applied: win_y 232 -> 233.
REQ-022 win_x=632, right request, macro undefined -> win_x stays 632; macro defined -> win_x=0.
REQ-023 mv_valid on the apply clk, then reset pulsed mid-frame -> win_x and win_y return to 316 and 232; pending move never applied.
